// File: rtl/nexi_uart_pkg.sv
// nexi_uart_pkg
//   Shared definitions for the UART receive front end: the one-hot FSM state
//   encoding, oversampling constants and the 2-of-3 majority helper used when
//   NEXI_UART_RX_MAJORITY_EN is defined.
package nexi_uart_pkg;

  // Ticks per bit and the tick indices used for bit decisions.
  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_MID = 7;
  localparam int MAJ_LO     = 6;
  localparam int MAJ_HI     = 8;

  // Receiver FSM, one-hot.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_START = 4'b0010,
    ST_DATA  = 4'b0100,
    ST_STOP  = 4'b1000
  } rx_state_e;

  // 2-of-3 majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/nexi_uart_rx_frontend_if.sv
// nexi_uart_rx_frontend_if
//   Byte handshake between the UART receive front end (master) and the
//   register block RX FSM (slave).
//   data       : received character, valid while data_ready
//   data_ready : level, byte available
//   frame_err  : stop bit was sampled low for the presented byte
//   overrun    : a completed byte was dropped
//   read_ack   : level acknowledge from the consumer
interface nexi_uart_rx_frontend_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] data;
  logic                  data_ready;
  logic                  frame_err;
  logic                  overrun;
  logic                  read_ack;

  modport master (
    output data,
    output data_ready,
    output frame_err,
    output overrun,
    input  read_ack
  );

  modport slave (
    input  data,
    input  data_ready,
    input  frame_err,
    input  overrun,
    output read_ack
  );

endinterface

// File: rtl/nexi_uart_baud_tick.sv
// nexi_uart_baud_tick
//   Divides clk_i by CLK_DIV to produce the 16x oversampling tick.
//   Ports:
//     clk_i : clock
//     rst_i : synchronous reset, active high
//     clr   : restart the divider at 0 (start-bit alignment)
//     tick  : high while the divider sits at CLK_DIV-1 (one cycle per period)
module nexi_uart_baud_tick #(
  parameter int CLK_DIV = 27
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  output logic tick
);

  localparam int              DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_nxt_s;

  // Next divider value: clear on request, wrap at CLK_DIV-1.
  always_comb begin
    div_nxt_s = div_r;
    if (clr) begin
      div_nxt_s = {DIV_W{1'b0}};
    end else if (div_r == DIV_LAST) begin
      div_nxt_s = {DIV_W{1'b0}};
    end else begin
      div_nxt_s = div_r + DIV_W'(1);
    end
  end

  // Divider state; tick is registered from the next value so it always
  // equals (div_r == CLK_DIV-1) without a combinational output path.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_r <= {DIV_W{1'b0}};
      tick  <= 1'b0;
    end else begin
      div_r <= div_nxt_s;
      tick  <= (div_nxt_s == DIV_LAST);
    end
  end

endmodule

// File: rtl/nexi_uart_rx_frontend.sv
// nexi_uart_rx_frontend
//   UART 8N1 receive front end: 2-flop synchroniser on rx_pin, 16x
//   oversampling tick, start/data/stop deframing and a level data_ready /
//   read_ack handshake towards the 16550-style register block.
//   Ports:
//     clk_i  : single clock
//     rst_i  : synchronous reset, active high (aborts any frame in flight)
//     rx_pin : asynchronous serial input, idle high
//     rx_bus : nexi_uart_rx_frontend_if.master (data, data_ready,
//              frame_err, overrun out; read_ack in)
//   Build option:
//     NEXI_UART_RX_MAJORITY_EN : decide each bit by a 2-of-3 vote of the
//     samples at scnt 6/7/8 (decision on scnt 8). Undefined: single sample
//     at scnt 7.
module nexi_uart_rx_frontend
  import nexi_uart_pkg::*;
#(
  parameter int CLK_DIV    = 27,
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           rx_pin,
  nexi_uart_rx_frontend_if.master        rx_bus
);

  localparam int               IDX_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

`ifdef NEXI_UART_RX_MAJORITY_EN
  localparam logic [3:0] DECIDE_CNT = 4'(MAJ_HI);
`else
  localparam logic [3:0] DECIDE_CNT = 4'(SAMPLE_MID);
`endif

  logic                  rx_meta_r;
  logic                  rx_sync_r;
  rx_state_e             state_r;
  logic                  armed_r;
  logic [3:0]            scnt_r;
  logic [IDX_W-1:0]      idx_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  data_ready_r;
  logic                  frame_err_r;
  logic                  overrun_r;

  logic                  tick_s;
  logic                  start_s;
  logic                  decide_s;
  logic                  bit_s;

  // Two-flop synchroniser; both stages reset to the idle (high) level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_pin;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Start recognition: only an armed receiver accepts a falling line, so a
  // held-low line produces a single frame.
  always_comb begin
    start_s = 1'b0;
    if ((state_r == ST_IDLE) && armed_r && !rx_sync_r) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
  end

  nexi_uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (start_s),
    .tick  (tick_s)
  );

`ifdef NEXI_UART_RX_MAJORITY_EN
  logic [1:0] maj_smp_r;

  // Capture the scnt 6 and 7 samples; the scnt 8 sample is taken live.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      maj_smp_r <= 2'b11;
    end else if (tick_s && (scnt_r == 4'(MAJ_LO))) begin
      maj_smp_r[0] <= rx_sync_r;
    end else if (tick_s && (scnt_r == 4'(SAMPLE_MID))) begin
      maj_smp_r[1] <= rx_sync_r;
    end else begin
      maj_smp_r <= maj_smp_r;
    end
  end

  // Bit value is the vote of the three samples around mid-bit.
  always_comb begin
    bit_s = maj3(maj_smp_r[0], maj_smp_r[1], rx_sync_r);
  end
`else
  // Bit value is the single mid-bit sample.
  always_comb begin
    bit_s = rx_sync_r;
  end
`endif

  // Decision strobe: the tick on which the current bit is resolved.
  always_comb begin
    decide_s = 1'b0;
    if (tick_s && (scnt_r == DECIDE_CNT)) begin
      decide_s = 1'b1;
    end else begin
      decide_s = 1'b0;
    end
  end

  // Deframing FSM with registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      armed_r      <= 1'b0;
      scnt_r       <= 4'd0;
      idx_r        <= {IDX_W{1'b0}};
      shift_r      <= {DATA_WIDTH{1'b0}};
      data_r       <= {DATA_WIDTH{1'b0}};
      data_ready_r <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      // scnt free-runs on ticks and wraps 15->0; the start branch realigns it.
      if (tick_s) begin
        scnt_r <= scnt_r + 4'd1;
      end

      // Consumer acknowledge clears data_ready one cycle later.
      if (data_ready_r && rx_bus.read_ack) begin
        data_ready_r <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (rx_sync_r) begin
            armed_r <= 1'b1;
          end else if (start_s) begin
            armed_r <= 1'b0;
            state_r <= ST_START;
            scnt_r  <= 4'd0;
            idx_r   <= {IDX_W{1'b0}};
          end
        end

        ST_START: begin
          if (decide_s) begin
            // A high line at mid start bit is a glitch, not a start.
            state_r <= bit_s ? ST_IDLE : ST_DATA;
          end
        end

        ST_DATA: begin
          if (decide_s) begin
            shift_r[idx_r] <= bit_s;
            if (idx_r == IDX_LAST) begin
              state_r <= ST_STOP;
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end
        end

        ST_STOP: begin
          if (decide_s) begin
            // A pending byte or an ack still high means the new byte cannot
            // be presented this cycle: drop it and flag overrun.
            if (!data_ready_r && !rx_bus.read_ack) begin
              data_r       <= shift_r;
              frame_err_r  <= ~bit_s;
              data_ready_r <= 1'b1;
              overrun_r    <= 1'b0;
            end else begin
              overrun_r    <= 1'b1;
            end
            state_r <= ST_IDLE;
          end
        end

        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_bus.data       = data_r;
  assign rx_bus.data_ready = data_ready_r;
  assign rx_bus.frame_err  = frame_err_r;
  assign rx_bus.overrun    = overrun_r;

endmodule
